// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Sits between two frame requesters and a single UART transmitter. When it is
//   idle it picks one requester, round-robin under contention. It latches that
//   requester's byte and parity settings, strobes the transmitter for one cycle
//   and then follows the transmitter's BUSY until the frame has gone out. It
//   gives each requester a one-cycle grant and a one-cycle done pulse. It can
//   hold off the next grant for a fixed number of idle cycles. It raises a
//   one-cycle error if the transmitter never starts.
//
// Handshake:
//   A requester holds REQx high, together with stable DATAx/PAR_ENx/PAR_TYPx,
//   until it sees GNTx. GNTx is high for one cycle and means the inputs were
//   latched at the previous edge. After that the requester may change them
//   freely. If REQx is still high when the arbiter is back in IDLE, it counts
//   as a new request.
//
// Ports:
//   CLK            system clock, rising edge
//   RST            asynchronous active-low reset
//   REQ0/REQ1      frame requests (level)
//   DATA0/DATA1    requester bytes
//   PAR_EN0/1      requester parity enable
//   PAR_TYP0/1     requester parity type (0 even, 1 odd)
//   TX_BUSY        BUSY from the transmitter
//   GNT0/GNT1      one-cycle grant pulses
//   DONE0/DONE1    one-cycle frame-complete pulses
//   TX_P_DATA      byte to the transmitter (held until the next grant)
//   TX_PAR_EN      parity enable to the transmitter
//   TX_PAR_TYP     parity type to the transmitter
//   TX_DATA_VALID  one-cycle start strobe to the transmitter
//   TIMEOUT_ERR    one-cycle pulse when the transmitter never raised BUSY
//   BUSY           high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int DATA_LENGTH   = 8,
   parameter int START_TIMEOUT = 4,
   parameter int GAP_CYCLES    = 0
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   REQ0,
   input  logic [DATA_LENGTH-1:0] DATA0,
   input  logic                   PAR_EN0,
   input  logic                   PAR_TYP0,
   input  logic                   REQ1,
   input  logic [DATA_LENGTH-1:0] DATA1,
   input  logic                   PAR_EN1,
   input  logic                   PAR_TYP1,
   input  logic                   TX_BUSY,
   output logic                   GNT0,
   output logic                   GNT1,
   output logic                   DONE0,
   output logic                   DONE1,
   output logic [DATA_LENGTH-1:0] TX_P_DATA,
   output logic                   TX_PAR_EN,
   output logic                   TX_PAR_TYP,
   output logic                   TX_DATA_VALID,
   output logic                   TIMEOUT_ERR,
   output logic                   BUSY
);

   // Gap counter runs 0 .. GAP_CYCLES-1. When GAP_CYCLES is 0 the GAP state is
   // never entered, so the width and terminal value are don't-cares.
   localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [3:0]      TO_LAST  = 4'(START_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_GAP       = 3'd4
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   state_t                 w_end_state;

   logic                   r_last;        // requester served most recently
   logic [3:0]             r_to_cnt;
   logic [GW-1:0]          r_gap_cnt;
   logic [DATA_LENGTH-1:0] r_data;
   logic                   r_par_en;
   logic                   r_par_typ;
   logic                   r_gnt0;
   logic                   r_gnt1;
   logic                   r_done0;
   logic                   r_done1;
   logic                   r_valid;
   logic                   r_err;
   logic                   r_busy;

   logic                   w_last_nxt;
   logic [3:0]             w_to_nxt;
   logic [GW-1:0]          w_gap_nxt;
   logic [DATA_LENGTH-1:0] w_data_nxt;
   logic                   w_par_en_nxt;
   logic                   w_par_typ_nxt;
   logic                   w_gnt0_nxt;
   logic                   w_gnt1_nxt;
   logic                   w_done0_nxt;
   logic                   w_done1_nxt;
   logic                   w_valid_nxt;
   logic                   w_err_nxt;
   logic                   w_pick1;

   // Requester 1 wins when it asks alone, or when both ask and requester 0 was
   // the one served last.
   assign w_pick1 = REQ1 & (~REQ0 | ~r_last);

   always_comb begin
      w_state_nxt   = r_state;
      w_end_state   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      w_last_nxt    = r_last;
      w_to_nxt      = r_to_cnt;
      w_gap_nxt     = r_gap_cnt;
      w_data_nxt    = r_data;
      w_par_en_nxt  = r_par_en;
      w_par_typ_nxt = r_par_typ;
      w_gnt0_nxt    = 1'b0;
      w_gnt1_nxt    = 1'b0;
      w_done0_nxt   = 1'b0;
      w_done1_nxt   = 1'b0;
      w_valid_nxt   = 1'b0;
      w_err_nxt     = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (REQ0 | REQ1) begin
               if (w_pick1) begin
                  w_data_nxt    = DATA1;
                  w_par_en_nxt  = PAR_EN1;
                  w_par_typ_nxt = PAR_TYP1;
                  w_gnt1_nxt    = 1'b1;
                  w_last_nxt    = 1'b1;
               end else begin
                  w_data_nxt    = DATA0;
                  w_par_en_nxt  = PAR_EN0;
                  w_par_typ_nxt = PAR_TYP0;
                  w_gnt0_nxt    = 1'b1;
                  w_last_nxt    = 1'b0;
               end
               w_valid_nxt = 1'b1;
               w_state_nxt = S_LOAD;
            end
         end

         S_LOAD: begin
            w_to_nxt    = 4'd0;
            w_state_nxt = S_WAIT_BUSY;
         end

         S_WAIT_BUSY: begin
            if (TX_BUSY) begin
               w_state_nxt = S_WAIT_DONE;
            end else if (r_to_cnt == TO_LAST) begin
               // START_TIMEOUT cycles spent here without BUSY: abandon the frame.
               w_err_nxt   = 1'b1;
               w_to_nxt    = 4'd0;
               w_gap_nxt   = '0;
               w_state_nxt = w_end_state;
            end else begin
               w_to_nxt = r_to_cnt + 4'd1;
            end
         end

         S_WAIT_DONE: begin
            if (!TX_BUSY) begin
               // The pointer still names the requester that owns this frame.
               w_done0_nxt = ~r_last;
               w_done1_nxt = r_last;
               w_gap_nxt   = '0;
               w_state_nxt = w_end_state;
            end
         end

         S_GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
               w_gap_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_gap_nxt = r_gap_cnt + GW'(1);
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= S_IDLE;
         r_last    <= 1'b1;
         r_to_cnt  <= 4'd0;
         r_gap_cnt <= '0;
         r_data    <= '0;
         r_par_en  <= 1'b0;
         r_par_typ <= 1'b0;
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_done0   <= 1'b0;
         r_done1   <= 1'b0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_last    <= w_last_nxt;
         r_to_cnt  <= w_to_nxt;
         r_gap_cnt <= w_gap_nxt;
         r_data    <= w_data_nxt;
         r_par_en  <= w_par_en_nxt;
         r_par_typ <= w_par_typ_nxt;
         r_gnt0    <= w_gnt0_nxt;
         r_gnt1    <= w_gnt1_nxt;
         r_done0   <= w_done0_nxt;
         r_done1   <= w_done1_nxt;
         r_valid   <= w_valid_nxt;
         r_err     <= w_err_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
      end
   end

   assign GNT0          = r_gnt0;
   assign GNT1          = r_gnt1;
   assign DONE0         = r_done0;
   assign DONE1         = r_done1;
   assign TX_P_DATA     = r_data;
   assign TX_PAR_EN     = r_par_en;
   assign TX_PAR_TYP    = r_par_typ;
   assign TX_DATA_VALID = r_valid;
   assign TIMEOUT_ERR   = r_err;
   assign BUSY          = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Testbench for uart_tx_arbiter. Requester drivers push the frame they offer
// onto per-requester expected queues. A transmitter model pushes the expected
// completion (done or timeout, and the cycle it should appear) when it sees the
// start strobe. A negedge monitor predicts grants from the request history
// using the round-robin rule and checks every output each cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int DW  = 8;
   localparam int ST  = 4;
   localparam int GAP = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req [2];
   logic [DW-1:0] dat [2];
   logic          pe  [2];
   logic          pt  [2];
   logic          model_busy;
   logic          spur_busy;
   logic          tx_busy;

   logic          gnt0, gnt1, done0, done1, txv, err, busy_o, txpe, txpt;
   logic [DW-1:0] txd;

   assign tx_busy = model_busy | spur_busy;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .DATA_LENGTH   (DW),
      .START_TIMEOUT (ST),
      .GAP_CYCLES    (GAP)
   ) dut (
      .CLK           (clk),
      .RST           (rst_n),
      .REQ0          (req[0]),
      .DATA0         (dat[0]),
      .PAR_EN0       (pe[0]),
      .PAR_TYP0      (pt[0]),
      .REQ1          (req[1]),
      .DATA1         (dat[1]),
      .PAR_EN1       (pe[1]),
      .PAR_TYP1      (pt[1]),
      .TX_BUSY       (tx_busy),
      .GNT0          (gnt0),
      .GNT1          (gnt1),
      .DONE0         (done0),
      .DONE1         (done1),
      .TX_P_DATA     (txd),
      .TX_PAR_EN     (txpe),
      .TX_PAR_TYP    (txpt),
      .TX_DATA_VALID (txv),
      .TIMEOUT_ERR   (err),
      .BUSY          (busy_o)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp_v);
      end
   endfunction

   // ---------------- scoreboard state ----------------
   typedef struct packed {
      logic        err;
      logic [31:0] cyc;
   } out_t;

   logic [DW+1:0] exp_q0 [$];
   logic [DW+1:0] exp_q1 [$];
   out_t          out_q  [$];

   bit            mon_en   = 1'b0;
   int            free_at  = 0;      // first cycle the arbiter is idle again
   bit            outst    = 1'b0;   // a frame is granted and not yet finished
   bit            last     = 1'b1;
   bit            served   = 1'b0;
   logic [1:0]    prev_req = 2'b00;
   logic [DW+1:0] exp_tx   = '0;
   int            tx_force = 0;      // 0 random, 1 fixed d=1/L=10, 2 never start

   // ---------------- transmitter model ----------------
   initial begin
      int   d, l;
      bit   to_f;
      out_t o;
      model_busy = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rst_n && txv) begin
            if (tx_force == 2) begin
               to_f = 1'b1;
               d = 0;
               l = 0;
            end else if (tx_force == 1) begin
               to_f = 1'b0;
               d = 1;
               l = 10;
            end else begin
               to_f = ($urandom_range(0, 4) == 0);
               d = $urandom_range(1, ST);
               l = $urandom_range(1, 12);
            end
            if (to_f) begin
               // ST cycles in WAIT_BUSY after the one-cycle LOAD.
               o.err = 1'b1;
               o.cyc = 32'(cyc + ST + 1);
               out_q.push_back(o);
            end else begin
               // BUSY high for cycles s+d .. s+d+l-1; done one cycle after it falls.
               o.err = 1'b0;
               o.cyc = 32'(cyc + d + l + 1);
               out_q.push_back(o);
               for (int k = 0; k < d; k++) begin
                  @(posedge clk); #1;
                  if (!rst_n) break;
               end
               if (rst_n) begin
                  model_busy = 1'b1;
                  for (int k = 0; k < l; k++) begin
                     @(posedge clk); #1;
                     if (!rst_n) break;
                  end
               end
               model_busy = 1'b0;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      int         c;
      logic [1:0] eg;
      logic [2:0] ed;
      logic [1:0] cur_req;
      cur_req = {req[1], req[0]};
      c = cyc;
      if (mon_en) begin
         eg = 2'b00;
         if (!outst && (c - 1) >= free_at && prev_req != 2'b00) begin
            if (prev_req == 2'b11) eg = last ? 2'b01 : 2'b10;
            else                   eg = prev_req;
         end
         check("gnt", {30'd0, gnt1, gnt0}, {30'd0, eg});
         check("strobe", {31'd0, txv}, {31'd0, (eg != 2'b00)});
         if (eg != 2'b00) begin
            if (eg[1] == 1'b0 && exp_q0.size() != 0)     exp_tx = exp_q0.pop_front();
            else if (eg[1] == 1'b1 && exp_q1.size() != 0) exp_tx = exp_q1.pop_front();
            else check("gnt_expq_empty", 32'd1, 32'd0);
            outst  = 1'b1;
            served = eg[1];
            last   = eg[1];
         end
         check("tx_cfg", {22'd0, txd, txpe, txpt}, {22'd0, exp_tx});
         while (out_q.size() != 0 && out_q[0].cyc < 32'(c)) begin
            check("stale_outcome", 32'd1, 32'd0);
            void'(out_q.pop_front());
         end
         ed = 3'b000;
         if (out_q.size() != 0 && out_q[0].cyc == 32'(c)) begin
            ed = out_q[0].err ? 3'b100 : (served ? 3'b010 : 3'b001);
            void'(out_q.pop_front());
            outst   = 1'b0;
            free_at = c + GAP;
         end
         check("done_err", {29'd0, err, done1, done0}, {29'd0, ed});
         check("busy", {31'd0, busy_o}, {31'd0, !(!outst && c >= free_at)});
      end
      prev_req = cur_req;
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Called just after a rising edge; returns just after the edge that shows GNTx.
   task automatic send(input int x, input logic [DW-1:0] d, input logic p_e,
                       input logic p_t, input bit keep);
      int n;
      bit g;
      dat[x] = d;
      pe[x]  = p_e;
      pt[x]  = p_t;
      req[x] = 1'b1;
      if (x == 0) exp_q0.push_back({d, p_e, p_t});
      else        exp_q1.push_back({d, p_e, p_t});
      n = 0;
      g = 1'b0;
      while (!g && n < 400) begin
         @(posedge clk); #1;
         n++;
         g = (x == 0) ? gnt0 : gnt1;
      end
      check("gnt_wait", {31'd0, g}, 32'd1);
      if (!keep) req[x] = 1'b0;
   endtask

   task automatic release_reset();
      rst_n   = 1'b1;
      free_at = cyc;
      outst   = 1'b0;
      last    = 1'b1;
      exp_tx  = '0;
      out_q.delete();
      mon_en  = 1'b1;
   endtask

   task automatic contend(input int x);
      for (int k = 0; k < 3; k++)
         send(x, DW'($urandom), 1'($urandom), 1'($urandom), (k < 2));
   endtask

   task automatic rand_requester(input int x);
      bit held = 1'b0;
      bit kp;
      for (int i = 0; i < 12; i++) begin
         kp = (i < 11) && ($urandom_range(0, 2) == 0);
         if (!held) idle($urandom_range(0, 6));
         send(x, DW'($urandom), 1'($urandom), 1'($urandom), kp);
         held = kp;
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      rst_n     = 1'b0;
      spur_busy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0;
         dat[i] = '0;
         pe[i]  = 1'b0;
         pt[i]  = 1'b0;
      end
      #1;
      check("reset_outputs",
            {15'd0, gnt0, gnt1, done0, done1, txv, err, busy_o, txpe, txpt, txd}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      release_reset();

      // single request: A5, parity even enabled, BUSY 1 cycle after strobe for 10
      tx_force = 1;
      send(0, 8'hA5, 1'b1, 1'b0, 1'b0);
      idle(25);

      // contention: both held for three frames each
      tx_force = 0;
      fork
         contend(0);
         contend(1);
      join
      idle(30);

      // start timeout, then a normal frame afterwards
      tx_force = 2;
      send(1, 8'h3C, 1'b1, 1'b1, 1'b0);
      idle(15);
      tx_force = 1;
      send(0, 8'hC3, 1'b0, 1'b1, 1'b0);
      idle(25);

      // spurious BUSY while idle with no requests
      spur_busy = 1'b1;
      idle(3);
      spur_busy = 1'b0;
      idle(5);

      // randomized traffic on both requesters
      tx_force = 0;
      fork
         rand_requester(0);
         rand_requester(1);
      join
      idle(60);

      // reset during WAIT_DONE, then a lone REQ1
      tx_force = 1;
      send(0, 8'h5A, 1'b1, 1'b1, 1'b0);
      idle(4);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("async_reset_outputs",
            {15'd0, gnt0, gnt1, done0, done1, txv, err, busy_o, txpe, txpt, txd}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      release_reset();
      send(1, 8'h81, 1'b0, 1'b0, 1'b0);
      idle(25);

      // reset again while idle, then both request together
      mon_en = 1'b0;
      rst_n  = 1'b0;
      idle(2);
      release_reset();
      fork
         send(0, 8'h0F, 1'b1, 1'b0, 1'b0);
         send(1, 8'hF0, 1'b0, 1'b1, 1'b0);
      join
      idle(40);

      check("drained_queues", 32'(exp_q0.size() + exp_q1.size() + out_q.size()), 32'd0);
      check("drained_outstanding", {31'd0, outst}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Two-requester scheduler in front of the UART transmit top (P_DATA / PAR_EN / PAR_TYP / DATA_VALID in, BUSY out).
- Arbitrates round-robin between requesters and latches the winner's byte and parity configuration.
- Issues a one-cycle DATA_VALID to the transmitter, then tracks its BUSY to completion.
- Returns per-requester grant and done pulses, enforces a configurable inter-frame gap, and flags a transmitter that never starts.

Parameters:
DATA_LENGTH, 8, frame data width; must match the transmitter's DATA_LENGTH
START_TIMEOUT, 4, max cycles in WAIT_BUSY for TX_BUSY to rise before abort (1..15)
GAP_CYCLES, 0, idle cycles forced between a frame end and the next grant (0 = no GAP state)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous active-low reset
REQ0  in  1  requester 0 frame request, level; held until GNT0
DATA0  in  DATA_LENGTH  requester 0 byte
PAR_EN0  in  1  requester 0 parity enable
PAR_TYP0  in  1  requester 0 parity type (0 even, 1 odd)
REQ1  in  1  requester 1 frame request
DATA1  in  DATA_LENGTH  requester 1 byte
PAR_EN1  in  1  requester 1 parity enable
PAR_TYP1  in  1  requester 1 parity type
TX_BUSY  in  1  BUSY from the transmitter
GNT0  out  1  one-cycle pulse: requester 0 data latched
GNT1  out  1  one-cycle pulse: requester 1 data latched
DONE0  out  1  one-cycle pulse: requester 0 frame completed
DONE1  out  1  one-cycle pulse: requester 1 frame completed
TX_P_DATA  out  DATA_LENGTH  byte to the transmitter
TX_PAR_EN  out  1  parity enable to the transmitter
TX_PAR_TYP  out  1  parity type to the transmitter
TX_DATA_VALID  out  1  one-cycle start strobe to the transmitter
TIMEOUT_ERR  out  1  one-cycle pulse on start timeout
BUSY  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous, active-low.
- Reset values: all outputs registered and 0, including TX_P_DATA. State = IDLE, timeout/gap counters = 0, last-served pointer = 1 (requester 0 wins first contention).
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: sample REQ0/REQ1.
  - Only one asserted: select it.
  - Both asserted: select the requester not equal to the last-served pointer.
  - On selection at edge T: TX_P_DATA/TX_PAR_EN/TX_PAR_TYP latch the winner's inputs, GNTx=1, TX_DATA_VALID=1, pointer updates, state goes to LOAD. All visible in cycle T+1.
  - No request: stay in IDLE.
- LOAD (one cycle): GNTx and TX_DATA_VALID return to 0 next edge. Go to WAIT_BUSY and clear the timeout counter.
- WAIT_BUSY:
  - TX_BUSY=1: go to WAIT_DONE.
  - Otherwise the counter increments. When it reaches START_TIMEOUT, pulse TIMEOUT_ERR, give no DONE, and go to GAP (or IDLE if GAP_CYCLES=0).
- WAIT_DONE: on TX_BUSY=0, pulse DONEx for the served requester, then go to GAP (or IDLE if GAP_CYCLES=0).
- GAP: stay for exactly GAP_CYCLES cycles, then IDLE. Requests are ignored (not granted) during GAP.
- TX_P_DATA/TX_PAR_* hold stable from LOAD until the next grant. Requester inputs may change freely after GNT.
- REQx still high in IDLE after its GNT is treated as a new request. A lone persistent requester is served back-to-back; round-robin applies only under contention.
- Minimum frame-to-frame spacing at the transmitter: strobe, BUSY period, GAP_CYCLES, then one IDLE evaluation cycle.
- TX_BUSY glitching high in IDLE/LOAD/GAP is ignored.
- Reset asserted mid-frame: immediate return to reset values. No DONE or ERR is generated for the aborted frame.
- Exactly one of GNT0/GNT1 can be high in a cycle; same for DONE0/DONE1.
- GNT and DONE never coincide for the same frame.

Test Plan:
- Single request: REQ0=1, DATA0=8'hA5, PAR_EN0=1, PAR_TYP0=0; transmitter model raises TX_BUSY 1 cycle after strobe and holds it 10 cycles -> GNT0 and TX_DATA_VALID single pulse with TX_P_DATA=A5, TX_PAR_EN=1, TX_PAR_TYP=0; DONE0 one cycle after TX_BUSY falls; BUSY high throughout.
- Contention: REQ0 and REQ1 both held for 3 frames -> grant order 0,1,0; TX_P_DATA follows DATA0/DATA1 per frame; DONE order matches.
- Start timeout: TX_BUSY tied 0, START_TIMEOUT=4 -> TIMEOUT_ERR pulse 4 cycles after LOAD; no DONE; arbiter returns to IDLE and grants the next request.
- Gap: GAP_CYCLES=3, REQ1 held continuously -> exactly 3 GAP cycles plus 1 IDLE cycle between DONE1 and next GNT1.
- Reset mid-frame: RST low during WAIT_DONE -> all outputs 0 asynchronously. After release with REQ1 alone, GNT1 appears; with both requesting, requester 0 wins.
- Spurious busy: TX_BUSY pulsed high in IDLE with no requests -> no state change, BUSY stays 0, no DONE or ERR.
